// File: rtl/div_iter_ctrl_pkg.sv
// Shared definitions for the iterative radix-2 divider: default widths and
// the sequencing FSM state encoding.
package div_iter_ctrl_pkg;

   localparam int DIV_DATA_W = 32;   // operand/result width
   localparam int DIV_CNT_W  = 5;    // iteration counter width, log2(DIV_DATA_W)

   // Sequencing states of the divider.
   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,   // waiting for a request
      DIV_CALC = 2'd1,   // one restoring step per cycle
      DIV_FIX  = 2'd2,   // apply quotient/remainder signs
      DIV_DONE = 2'd3    // result valid, waiting for res_ack
   } div_state_e;

endpackage : div_iter_ctrl_pkg

// File: rtl/div_iter_ctrl_div_step.sv
// One restoring division iteration, purely combinational. Kept as its own
// block so several copies can later be chained for a higher radix.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] r_in,
   input  logic [DATA_W-1:0] q_in,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] r_out,
   output logic [DATA_W-1:0] q_out
);

   logic [DATA_W:0] r_sh;

   // Shift {r,q} left by one, then subtract the divisor if it fits.
   always_comb begin
      // NOTE: r_sh needs DATA_W+1 bits because 2r+1 can exceed DATA_W bits
      // when the divisor is large; only the low bits survive the subtract.
      r_sh = {r_in, q_in[DATA_W-1]};
      if (r_sh >= {1'b0, d}) begin
         r_out = r_sh[DATA_W-1:0] - d;
         q_out = {q_in[DATA_W-2:0], 1'b1};
      end else begin
         r_out = r_sh[DATA_W-1:0];
         q_out = {q_in[DATA_W-2:0], 1'b0};
      end
   end

endmodule : div_step

// File: rtl/div_iter_ctrl.sv
// Iterative radix-2 divider with its sequencing FSM for the EX stage.
// Accepts one request in IDLE, runs DATA_W restoring steps, fixes signs,
// then holds quotient and remainder valid until EX acknowledges them.
module div_iter_ctrl
   import div_iter_ctrl_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W,
   parameter int CNT_W  = DIV_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              div_req,
   input  logic              div_signed,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   input  logic              flush,
   input  logic              res_ack,
   output logic              div_busy,
   output logic              div_done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] r_q, r_d;        // partial remainder
   logic [DATA_W-1:0] q_q, q_d;        // quotient being shifted in
   logic [DATA_W-1:0] d_q, d_d;        // |divisor|
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic [DATA_W-1:0] quot_q, quot_d;
   logic [DATA_W-1:0] rem_q, rem_d;

   logic [DATA_W-1:0] step_r, step_q;
   logic [DATA_W-1:0] a_abs, b_abs;

   div_step #(.DATA_W(DATA_W)) u_step (
      .r_in  (r_q),
      .q_in  (q_q),
      .d     (d_q),
      .r_out (step_r),
      .q_out (step_q)
   );

   // Magnitudes of the operands; only signed ops take the absolute value.
   always_comb begin
      a_abs = (div_signed && dividend[DATA_W-1]) ? -dividend : dividend;
      b_abs = (div_signed && divisor[DATA_W-1])  ? -divisor  : divisor;
   end

   // Next-state, datapath and result update for the divider FSM.
   always_comb begin
      // NOTE: every signal assigned here gets a hold-value default first, so
      // no path through the case can leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      d_d     = d_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      if (flush) begin
         // Kill wins over everything; results are left as they were.
         state_d = DIV_IDLE;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (div_req) begin
                  if (divisor == '0) begin
                     quot_d  = '1;
                     rem_d   = dividend;
                     state_d = DIV_DONE;
                  end else begin
                     r_d     = '0;
                     q_d     = a_abs;
                     d_d     = b_abs;
                     q_neg_d = div_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                     r_neg_d = div_signed & dividend[DATA_W-1];
                     cnt_d   = '0;
                     state_d = DIV_CALC;
                  end
               end
            end
            DIV_CALC: begin
               r_d   = step_r;
               q_d   = step_q;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = DIV_FIX;
               end
            end
            DIV_FIX: begin
               quot_d  = q_neg_q ? -q_q : q_q;
               rem_d   = r_neg_q ? -r_q : r_q;
               state_d = DIV_DONE;
            end
            DIV_DONE: begin
               // div_req is gated by div_done upstream, so only res_ack matters.
               if (res_ack) begin
                  state_d = DIV_IDLE;
               end
            end
            default: state_d = DIV_IDLE;
         endcase
      end
   end

   // State, datapath and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   assign div_busy  = (state_q == DIV_CALC) || (state_q == DIV_FIX);
   assign div_done  = (state_q == DIV_DONE);
   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule : div_iter_ctrl
